// File: rtl/jtkcpu_busmst_pkg.sv
// Shared definitions for the jtkcpu bus initiator: state encoding and default widths.
package jtkcpu_busmst_pkg;

  localparam int AW_DEF   = 24;
  localparam int LENW_DEF = 12;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_FIN  = 3'd4
  } busmst_state_t;

endpackage

// File: rtl/jtkcpu_busmst_if.sv
// jtkcpu memory bus as seen by an initiator (master) and a responder/arbiter (slave).
interface jtkcpu_busmst_if #(
  parameter int AW = 24
);

  logic          bus_req;
  logic          bus_gnt;
  logic [AW-1:0] addr;
  logic [7:0]    dout;
  logic [7:0]    din;
  logic          we;
  logic          bwait;

  modport master (
    output bus_req, addr, dout, we,
    input  bus_gnt, din, bwait
  );

  modport slave (
    input  bus_req, addr, dout, we,
    output bus_gnt, din, bwait
  );

endinterface

// File: rtl/jtkcpu_busmst.sv
// Block-copy bus initiator for the jtkcpu bus: requests ownership, then reads src and
// writes dst one byte at a time in ascending order until the length counter runs out.
//
// state | meaning
// IDLE  | waiting for start; zero-length start only pulses done
// REQ   | bus_req high, waiting for bus_gnt on a cen clock
// RD    | read access to src pointer in flight
// WR    | write access to dst pointer in flight; grant re-checked on completion
// FIN   | release bus, pulse done
module jtkcpu_busmst
  import jtkcpu_busmst_pkg::*;
#(
  parameter int AW   = AW_DEF,
  parameter int LENW = LENW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen,
  input  logic            start,
  input  logic [AW-1:0]   src,
  input  logic [AW-1:0]   dst,
  input  logic [LENW-1:0] len,
  jtkcpu_busmst_if.master bus,
  output logic            busy,
  output logic            done
);

  busmst_state_t   r_state;
  logic [AW-1:0]   r_src;
  logic [AW-1:0]   r_dst;
  logic [LENW-1:0] r_cnt;
  logic            r_bus_req;
  logic [AW-1:0]   r_addr;
  logic [7:0]      r_dout;
  logic            r_we;
  logic            r_busy;
  logic            r_done;

  logic [AW-1:0]   w_src_nxt;
  logic [AW-1:0]   w_dst_nxt;
  logic [LENW-1:0] w_cnt_nxt;

  // Pointers wrap naturally at 2**AW; no carry is kept.
  assign w_src_nxt = r_src + 1'b1;
  assign w_dst_nxt = r_dst + 1'b1;
  assign w_cnt_nxt = r_cnt - 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_cnt     <= '0;
      r_bus_req <= 1'b0;
      r_addr    <= '0;
      r_dout    <= '0;
      r_we      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (len != '0) begin
              r_src     <= src;
              r_dst     <= dst;
              r_cnt     <= len;
              r_busy    <= 1'b1;
              r_bus_req <= 1'b1;
              r_state   <= ST_REQ;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (cen && bus.bus_gnt) begin
            r_addr  <= r_src;
            r_we    <= 1'b0;
            r_state <= ST_RD;
          end
        end
        ST_RD: begin
          if (cen && !bus.bwait) begin
            r_dout  <= bus.din;
            r_addr  <= r_dst;
            r_we    <= 1'b1;
            r_state <= ST_WR;
          end
        end
        ST_WR: begin
          // Grant is only honoured here, so an access already on the bus always finishes.
          if (cen && !bus.bwait) begin
            r_we  <= 1'b0;
            r_src <= w_src_nxt;
            r_dst <= w_dst_nxt;
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == '0) begin
              r_state <= ST_FIN;
            end else if (bus.bus_gnt) begin
              r_addr  <= w_src_nxt;
              r_state <= ST_RD;
            end else begin
              r_state <= ST_REQ;
            end
          end
        end
        ST_FIN: begin
          r_bus_req <= 1'b0;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.bus_req = r_bus_req;
  assign bus.addr    = r_addr;
  assign bus.dout    = r_dout;
  assign bus.we      = r_we;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule
